// File: rtl/dii_pkg.sv
// dii_pkg: shared DII flit types, widths and arbitration modes.
package dii_pkg;
  localparam int DII_DATA_WIDTH = 16;
  typedef struct packed {
    logic [DII_DATA_WIDTH-1:0] data;
    logic last;
    logic valid;
  } dii_flit;
  typedef enum logic {PRIO_RR, PRIO_FIXED} prio_mode_e;
  typedef enum logic {IDLE, LOCKED} worm_state_e;
endpackage

// File: rtl/dii_skid_buffer.sv
// dii_skid_buffer: 2-entry registered ready/valid stage; in_ready depends only on local state.
module dii_skid_buffer #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [WIDTH-1:0] skid_data;
  logic skid_valid;
  assign in_ready = !skid_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid  <= skid_valid | in_valid;
      out_data   <= skid_valid ? skid_data : in_data;
      skid_valid <= 1'b0;
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
endmodule

// File: rtl/dii_worm_mux_rr.sv
// dii_worm_mux_rr: packet-atomic N:1 DII mux with round-robin or fixed-priority arbitration.
module dii_worm_mux_rr import dii_pkg::*; #(
  parameter int NUM_IN     = 2,
  parameter int DATA_WIDTH = DII_DATA_WIDTH,
  parameter int PRIO_MODE  = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_IN-1:0][DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]                 in_last,
  input  logic [NUM_IN-1:0]                 in_valid,
  output logic [NUM_IN-1:0]                 in_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_last,
  output logic                              out_valid,
  input  logic                              out_ready
);
  localparam int IW = $clog2(NUM_IN);
  localparam prio_mode_e MODE = PRIO_MODE != 0 ? PRIO_FIXED : PRIO_RR;
  worm_state_e state, state_n;
  logic [IW-1:0] grant, grant_n, rr_ptr, rr_ptr_n, sel, idx, cur;
  logic any, core_valid, core_ready, core_last, fire;
  logic [DATA_WIDTH-1:0] core_data;
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % NUM_IN);
  endfunction
  // Descending scan from rr_ptr leaves the first valid index at or after rr_ptr.
  always_comb begin
    sel = '0;
    idx = '0;
    any = 1'b0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      idx = wrap(int'(rr_ptr) + k);
      if (in_valid[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end
  assign cur        = state == LOCKED ? grant : sel;
  assign core_valid = state == LOCKED ? in_valid[grant] : any;
  assign core_data  = in_data[cur];
  assign core_last  = in_last[cur];
  assign fire       = core_valid & core_ready;
  assign in_ready   = ((state == LOCKED || any) && core_ready) ? NUM_IN'(1) << cur : '0;
  always_comb begin
    state_n  = state;
    grant_n  = grant;
    rr_ptr_n = rr_ptr;
    if (fire && core_last) begin
      state_n  = IDLE;
      rr_ptr_n = MODE == PRIO_RR ? wrap(int'(cur) + 1) : '0;
    end else if (core_valid && state == IDLE) begin
      state_n = LOCKED;
      grant_n = sel;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      rr_ptr <= rr_ptr_n;
    end
  end
  generate
    if (OUT_REG != 0) begin : g_reg
      logic [DATA_WIDTH:0] skid_out;
      dii_skid_buffer #(.WIDTH(DATA_WIDTH + 1)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  ({core_last, core_data}),
        .in_valid (core_valid),
        .in_ready (core_ready),
        .out_data (skid_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
      );
      assign {out_last, out_data} = skid_out;
    end else begin : g_comb
      assign out_data   = core_data;
      assign out_last   = core_last;
      assign out_valid  = core_valid;
      assign core_ready = out_ready;
    end
  endgenerate
endmodule

// File: tb/tb_dii_worm_mux_rr.sv
// tb_dii_worm_mux_rr: random packet sources against a queue-based reference of the arbitration rules.
module tb_dii_worm_mux_rr;
  localparam int NA = 4, NB = 3, DW = 16;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [NA-1:0][DW-1:0] a_data;
  logic [NA-1:0] a_last, a_valid, a_ready;
  logic [DW-1:0] a_odata;
  logic a_olast, a_ovalid, a_oready;
  logic [NB-1:0][DW-1:0] b_data;
  logic [NB-1:0] b_last, b_valid, b_ready;
  logic [DW-1:0] b_odata;
  logic b_olast, b_ovalid, b_oready;
  dii_worm_mux_rr #(.NUM_IN(NA), .DATA_WIDTH(DW), .PRIO_MODE(0), .OUT_REG(0)) u_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_last(a_last), .in_valid(a_valid),
    .in_ready(a_ready), .out_data(a_odata), .out_last(a_olast), .out_valid(a_ovalid),
    .out_ready(a_oready));
  dii_worm_mux_rr #(.NUM_IN(NB), .DATA_WIDTH(DW), .PRIO_MODE(1), .OUT_REG(1)) u_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_last(b_last), .in_valid(b_valid),
    .in_ready(b_ready), .out_data(b_odata), .out_last(b_olast), .out_valid(b_ovalid),
    .out_ready(b_oready));
  int ncmp = 0, nerr = 0, cyc = 0;
  int p_val, lmin, lmax, rmode;
  logic [3:0] vld[2], lst[2];
  logic [DW-1:0] dat[2][4];
  logic ordy[2];
  int rem[2][4], seq[2][4];
  bit acc[2][4];
  bit locked[2];
  int grant[2], ptr[2];
  logic [DW:0] q[$];
  task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s dut=%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
    end
  endtask
  task automatic apply();
    for (int i = 0; i < NA; i++) a_data[i] = dat[0][i];
    for (int i = 0; i < NB; i++) b_data[i] = dat[1][i];
    a_valid = vld[0];
    a_last = lst[0];
    a_oready = ordy[0];
    b_valid = vld[1][NB-1:0];
    b_last = lst[1][NB-1:0];
    b_oready = ordy[1];
  endtask
  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < (d == 1 ? NB : NA); i++) begin
        if (acc[d][i]) begin
          acc[d][i] = 1'b0;
          vld[d][i] = 1'b0;
          rem[d][i]--;
          seq[d][i]++;
        end
        if (!vld[d][i] && $urandom_range(0, 99) < p_val) begin
          if (rem[d][i] == 0) rem[d][i] = $urandom_range(lmin, lmax);
          vld[d][i] = 1'b1;
          dat[d][i] = {2'(i), 2'(d), 12'(seq[d][i])};
          lst[d][i] = rem[d][i] == 1;
        end
      end
      ordy[d] = (rmode == 0) || (rmode == 1 ? cyc[0] : 1'($urandom_range(0, 1)));
    end
    apply();
  endtask
  task automatic model(int d);
    int n = d == 1 ? NB : NA;
    int w = 0;
    bit cv = 1'b0, cr, fire;
    logic [3:0] er, orr;
    logic ev, ov;
    logic [DW:0] eo, oo;
    if (locked[d]) begin
      w = grant[d];
      cv = vld[d][w];
    end else begin
      for (int k = 0; k < n; k++)
        if (!cv && vld[d][(ptr[d] + k) % n]) begin
          cv = 1'b1;
          w = (ptr[d] + k) % n;
        end
    end
    cr = d == 1 ? q.size() < 2 : ordy[d];
    er = ((cv || locked[d]) && cr) ? 4'(1 << w) : 4'd0;
    ev = d == 1 ? q.size() > 0 : cv;
    eo = d == 1 ? (q.size() > 0 ? q[0] : '0) : {lst[d][w], dat[d][w]};
    orr = d == 1 ? {1'b0, b_ready} : a_ready;
    ov = d == 1 ? b_ovalid : a_ovalid;
    oo = d == 1 ? {b_olast, b_odata} : {a_olast, a_odata};
    chk("in_ready", d, 32'(orr), 32'(er));
    chk("out_valid", d, 32'(ov), 32'(ev));
    if (ev) chk("out_flit", d, 32'(oo), 32'(eo));
    fire = cv && cr;
    if (d == 1) begin
      if (q.size() > 0 && ordy[d]) void'(q.pop_front());
      if (fire) q.push_back({lst[d][w], dat[d][w]});
    end
    if (fire) acc[d][w] = 1'b1;
    if (fire && lst[d][w]) begin
      locked[d] = 1'b0;
      if (d == 0) ptr[d] = (w + 1) % n;
    end else if (cv && !locked[d]) begin
      locked[d] = 1'b1;
      grant[d] = w;
    end
  endtask
  task automatic run(int n, int p, int l0, int l1, int rm);
    p_val = p;
    lmin = l0;
    lmax = l1;
    rmode = rm;
    repeat (n) begin
      drive();
      @(negedge clk);
      model(0);
      model(1);
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vld[d] = '0;
      lst[d] = '0;
      ordy[d] = 1'b1;
      locked[d] = 1'b0;
      ptr[d] = 0;
      grant[d] = 0;
      for (int i = 0; i < 4; i++) begin
        acc[d][i] = 1'b0;
        rem[d][i] = 0;
        dat[d][i] = '0;
      end
    end
    q.delete();
    apply();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 0, 32'(a_ovalid), 32'd0);
    chk("rst_out_valid", 1, 32'(b_ovalid), 32'd0);
    chk("rst_in_ready", 0, 32'(a_ready), 32'd0);
    chk("rst_in_ready", 1, 32'(b_ready), 32'd0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) seq[d][i] = 0;
    do_reset();
    run(40, 100, 1, 1, 0);
    run(60, 100, 3, 3, 0);
    run(200, 60, 1, 4, 2);
    run(120, 100, 8, 8, 1);
    run(7, 100, 4, 4, 0);
    do_reset();
    run(100, 70, 1, 5, 2);
    run(150, 30, 2, 6, 2);
    run(100, 90, 1, 3, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
